// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle for seq_alu.
//   in_valid/in_ready   : operand handshake (source -> ALU)
//   a, b, operation     : operands and 3-bit operation select
//   out_valid/out_ready : result handshake (ALU -> sink)
//   result, flags       : registered result and {carry, overflow, negative, zero}
// Modports: master = operand source / result sink side, slave = ALU side.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, operation, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, operation, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU with shifts, iterative multiply and status flags.
// One operation in flight at a time. Ops 000-110 complete at the accept edge; op 111
// (unsigned multiply, low WIDTH bits) runs WIDTH shift-add steps before the result.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_alu_if.slave (operand handshake in, result handshake out)
// Optional feature macro SEQ_ALU_FLAGS_EN: when defined, flags are computed with the
// result; when undefined, flags are tied to 4'b0000.
module seq_alu #(
    parameter  int unsigned WIDTH   = 8,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    localparam logic [SHAMT_W-1:0] LastStep = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0]   step_q, step_d;

    logic [WIDTH-1:0]     simple_res;
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign shamt = bus.b[SHAMT_W-1:0];

    // Single-cycle operations, evaluated on the live operands at the accept edge.
    always_comb begin
        simple_res = '0;
        unique case (bus.operation)
            OpAdd:   simple_res = bus.a + bus.b;
            OpSub:   simple_res = bus.a - bus.b;
            OpAnd:   simple_res = bus.a & bus.b;
            OpOr:    simple_res = bus.a | bus.b;
            OpXor:   simple_res = bus.a ^ bus.b;
            OpShl:   simple_res = bus.a << shamt;
            OpShr:   simple_res = bus.a >> shamt;
            OpMul:   simple_res = '0;
            default: simple_res = '0;
        endcase
    end

    // Right-shifting shift-add: upper half accumulates, lower half starts as the
    // multiplier and is consumed one bit per step. After WIDTH steps acc holds a*b.
    always_comb begin
        if (acc_q[0]) begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        end else begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic [3:0] simple_flags;
    logic [3:0] mul_flags;

    // flags = {carry, overflow, negative, zero}
    always_comb begin
        simple_flags    = '0;
        simple_flags[1] = simple_res[WIDTH-1];
        simple_flags[0] = (simple_res == '0);
        if (bus.operation == OpAdd) begin
            // Unsigned wrap happened iff the truncated sum is below an operand.
            simple_flags[3] = (simple_res < bus.a);
            simple_flags[2] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                              (simple_res[WIDTH-1] != bus.a[WIDTH-1]);
        end else if (bus.operation == OpSub) begin
            simple_flags[3] = (bus.a < bus.b);
            simple_flags[2] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                              (simple_res[WIDTH-1] != bus.a[WIDTH-1]);
        end
        mul_flags = {|mul_next[2*WIDTH-1:WIDTH], 1'b0, mul_next[WIDTH-1],
                     (mul_next[WIDTH-1:0] == '0)};
    end
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        a_d      = a_q;
        acc_d    = acc_q;
        step_d   = step_q;
`ifdef SEQ_ALU_FLAGS_EN
        flags_d  = flags_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.operation == OpMul) begin
                        a_d     = bus.a;
                        acc_d   = {{WIDTH{1'b0}}, bus.b};
                        step_d  = '0;
                        state_d = StMul;
                    end else begin
                        result_d = simple_res;
`ifdef SEQ_ALU_FLAGS_EN
                        flags_d  = simple_flags;
`endif
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                acc_d  = mul_next;
                step_d = step_q + 1'b1;
                if (step_q == LastStep) begin
                    result_d = mul_next[WIDTH-1:0];
`ifdef SEQ_ALU_FLAGS_EN
                    flags_d  = mul_flags;
`endif
                    step_d   = '0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            step_q   <= '0;
`ifdef SEQ_ALU_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
`ifdef SEQ_ALU_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
`ifdef SEQ_ALU_FLAGS_EN
    assign bus.flags     = flags_q;
`else
    assign bus.flags     = 4'b0000;
`endif

endmodule
